hub75_fb_arbiter: RTL and testbench
===================================

HUB75_FB_ARBITER -- requirements
Module: hub75_fb_arbiter

Interface
REQ-001 SHALL have parameter FB_AW, default 13, meaning frame buffer address width.
REQ-002 SHALL have parameter FB_DW, default 16, meaning frame buffer data width.
REQ-003 SHALL have parameter FB_MW, default FB_DW/4, meaning write-mask width (one bit per nibble).
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  reset: asynchronous, active-high.
REQ-006 rd_req  in  1  readout request; level, held until granted.
REQ-007 rd_gnt  out  1  readout grant; single-cycle pulse.
REQ-008 rd_rel  in  1  readout release; single-cycle pulse.
REQ-009 rd_addr  in  FB_AW  readout address.
REQ-010 wr_req, wr_gnt, wr_rel  in/out/in  1 each  writer request/grant/release, same rules as readout.
REQ-011 wr_addr  in  FB_AW  writer address.
REQ-012 wr_data  in  FB_DW  writer data.
REQ-013 wr_mask  in  FB_MW  writer nibble mask (1 = write).
REQ-014 wr_ena  in  1  writer write strobe.
REQ-015 fb_addr  out  FB_AW  frame buffer address.
REQ-016 fb_wr_data  out  FB_DW  frame buffer write data.
REQ-017 fb_wr_mask  out  FB_MW  frame buffer write mask.
REQ-018 fb_wr_ena  out  1  frame buffer write enable.
REQ-019 owner  out  2  current owner: 00 none, 01 readout, 10 writer.

Function
REQ-020 SHALL implement the states IDLE, OWN_RD and OWN_WR.
REQ-021 In IDLE at a clk edge, the state SHALL move to OWN_RD or OWN_WR per REQ-022/023 if any request is high, and otherwise stay in IDLE.
REQ-022 With only one request high in IDLE, that requester SHALL be chosen.
REQ-023 With both requests high in IDLE, readout SHALL be chosen, except when the previous owner was readout and the writer has been pending since before that grant, in which case the writer SHALL be chosen (one-deep anti-starvation; writer is never skipped twice in a row).
REQ-024 rd_gnt/wr_gnt SHALL be registered and high exactly during the first cycle of the corresponding OWN state; they SHALL never be high together.
REQ-025 Latency SHALL be: request high at edge N in IDLE -> grant high during cycle N..N+1 (first cycle after edge N).
REQ-026 The owner's release sampled at an edge SHALL return the state to IDLE at that edge; the next grant SHALL occur at the following edge at the earliest (one idle turnaround cycle).
REQ-027 A release from the non-owner, or any release in IDLE, SHALL be ignored.
REQ-028 A release coincident with a grant pulse cycle SHALL be honoured (zero-length ownership is legal).
REQ-029 The owner's own request SHALL be ignored while it holds the buffer; a request still high after release SHALL compete normally in IDLE.
REQ-030 fb_addr SHALL equal wr_addr in OWN_WR and rd_addr otherwise (combinational mux).
REQ-031 fb_wr_data/fb_wr_mask SHALL pass wr_data/wr_mask unconditionally.
REQ-032 fb_wr_ena SHALL equal wr_ena in OWN_WR and 0 in any other state; a writer strobe without ownership SHALL be dropped.
REQ-033 owner SHALL reflect the registered state with no extra latency.
REQ-034 There SHALL be no timeout; an owner never releasing holds the buffer indefinitely.

Reset
REQ-035 While rst is high: state IDLE, rd_gnt=0, wr_gnt=0, owner=00, fb_wr_ena=0, anti-starvation history cleared (previous owner = none).
REQ-036 Reset asserted mid-ownership SHALL abort it immediately with no grant or write pulse produced; after deassertion, pending requests SHALL be arbitrated from IDLE.

Verification
REQ-037 rd_req high at edge 1 -> rd_gnt pulse during cycle after edge 1, owner=01; rd_rel at edge 5 -> owner=00 after edge 5.
REQ-038 Both requests high continuously from IDLE with fresh history -> grant order rd, wr, rd, wr..., one idle cycle between owners.
REQ-039 Writer owns, wr_ena=1, wr_addr=0x0123, wr_data=0xBEEF, wr_mask=0xF -> fb_addr=0x0123, fb_wr_ena=1; same stimulus in IDLE/OWN_RD -> fb_wr_ena=0, fb_addr=rd_addr.
REQ-040 wr_rel pulsed during OWN_RD -> ignored, owner stays 01.
REQ-041 rst pulsed during OWN_WR with wr_ena=1 -> fb_wr_ena=0 and owner=00 immediately; with wr_req still high, wr_gnt re-issued on the first cycle after the first edge post-deassertion.

Source files
------------

// File: rtl/hub75_fb_arbiter.sv
// HUB75 frame buffer arbiter: shares one frame buffer port between the
// panel readout engine and a pixel writer. Readout wins ties, except that a
// writer already waiting when readout was last granted gets the next turn.
module hub75_fb_arbiter #(
    parameter int FB_AW = 13,
    parameter int FB_DW = 16,
    parameter int FB_MW = FB_DW / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_req,
    output logic             rd_gnt,
    input  logic             rd_rel,
    input  logic [FB_AW-1:0] rd_addr,
    input  logic             wr_req,
    output logic             wr_gnt,
    input  logic             wr_rel,
    input  logic [FB_AW-1:0] wr_addr,
    input  logic [FB_DW-1:0] wr_data,
    input  logic [FB_MW-1:0] wr_mask,
    input  logic             wr_ena,
    output logic [FB_AW-1:0] fb_addr,
    output logic [FB_DW-1:0] fb_wr_data,
    output logic [FB_MW-1:0] fb_wr_mask,
    output logic             fb_wr_ena,
    output logic [1:0]       owner
);

    // Encoding doubles as the owner output code.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_RD = 2'b01,
        OWN_WR = 2'b10
    } state_t;

    state_t state, state_nxt;
    // Set when readout was granted while the writer was already waiting;
    // cleared once the writer is served or stops asking.
    logic   wr_skip, wr_skip_nxt;

    // Next-state selection, release handling and anti-starvation history.
    always_comb begin
        state_nxt   = state;
        wr_skip_nxt = wr_skip;
        case (state)
            IDLE: begin
                if (rd_req && wr_req) state_nxt = wr_skip ? OWN_WR : OWN_RD;
                else if (rd_req)      state_nxt = OWN_RD;
                else if (wr_req)      state_nxt = OWN_WR;
            end
            OWN_RD:  if (rd_rel) state_nxt = IDLE;
            OWN_WR:  if (wr_rel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state == IDLE && state_nxt == OWN_RD)      wr_skip_nxt = wr_req;
        else if (state == IDLE && state_nxt == OWN_WR) wr_skip_nxt = 1'b0;
        else if (!wr_req)                              wr_skip_nxt = 1'b0;
    end

    // State, history and registered single-cycle grant pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_skip <= 1'b0;
            rd_gnt  <= 1'b0;
            wr_gnt  <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_skip <= wr_skip_nxt;
            rd_gnt  <= (state == IDLE) && (state_nxt == OWN_RD);
            wr_gnt  <= (state == IDLE) && (state_nxt == OWN_WR);
        end
    end

    // Buffer port mux; writer strobes outside writer ownership are dropped.
    always_comb begin
        fb_addr    = (state == OWN_WR) ? wr_addr : rd_addr;
        fb_wr_data = wr_data;
        fb_wr_mask = wr_mask;
        fb_wr_ena  = (state == OWN_WR) && wr_ena;
        owner      = state;
    end

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Bench for hub75_fb_arbiter: per-cycle vector table fed through a
// scoreboard queue, plus a hand-written reset-during-ownership sequence.
module tb_hub75_fb_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam logic [AW-1:0] RA = 13'h0AAA;
    localparam logic [AW-1:0] WA = 13'h0123;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req = 0, rd_rel = 0, wr_req = 0, wr_rel = 0, wr_ena = 0;
    logic [AW-1:0] rd_addr = RA, wr_addr = WA;
    logic [DW-1:0] wr_data = 16'hBEEF;
    logic [MW-1:0] wr_mask = 4'hF;
    logic          rd_gnt, wr_gnt, fb_wr_ena;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_wr_data;
    logic [MW-1:0] fb_wr_mask;
    logic [1:0]    owner;

    int n_cmp = 0;
    int n_bad = 0;

    hub75_fb_arbiter #(.FB_AW(AW), .FB_DW(DW), .FB_MW(MW)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_rel(rd_rel), .rd_addr(rd_addr),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_rel(wr_rel), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_ena(wr_ena),
        .fb_addr(fb_addr), .fb_wr_data(fb_wr_data), .fb_wr_mask(fb_wr_mask),
        .fb_wr_ena(fb_wr_ena), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rr, rl, wq, wl, we;   // inputs held across the edge
        logic [1:0] own;                   // expected after the edge
        logic       rg, wg, fe;
        logic [AW-1:0] fa;
        logic [DW-1:0] wd;
        logic [MW-1:0] wm;
    } vec_t;

    vec_t vecs[22];
    vec_t sb[$];

    function automatic vec_t mk(logic rr, logic rl, logic wq, logic wl, logic we,
                                logic [1:0] own, logic rg, logic wg, logic fe);
        vec_t v;
        v.rr = rr; v.rl = rl; v.wq = wq; v.wl = wl; v.we = we;
        v.own = own; v.rg = rg; v.wg = wg; v.fe = fe;
        v.fa = (own == 2'b10) ? WA : RA;
        v.wd = 16'hBEEF; v.wm = 4'hF;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        //            rr rl wq wl we   own  rg wg fe
        vecs[0]  = mk(0, 0, 0, 0, 1, 2'd0, 0, 0, 0); // idle strobe dropped
        vecs[1]  = mk(1, 0, 0, 0, 0, 2'd1, 1, 0, 0); // readout granted
        vecs[2]  = mk(1, 0, 0, 0, 1, 2'd1, 0, 0, 0); // own req ignored, no write
        vecs[3]  = mk(0, 0, 0, 1, 1, 2'd1, 0, 0, 0); // non-owner release ignored
        vecs[4]  = mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 0); // readout releases
        vecs[5]  = mk(0, 1, 0, 1, 1, 2'd0, 0, 0, 0); // releases in idle ignored
        vecs[6]  = mk(1, 0, 1, 0, 0, 2'd1, 1, 0, 0); // tie -> readout
        vecs[7]  = mk(1, 1, 1, 0, 0, 2'd0, 0, 0, 0); // release in grant cycle
        vecs[8]  = mk(1, 0, 1, 0, 1, 2'd2, 0, 1, 1); // waiting writer wins
        vecs[9]  = mk(1, 0, 1, 1, 1, 2'd0, 0, 0, 0);
        vecs[10] = mk(1, 0, 1, 0, 0, 2'd1, 1, 0, 0); // back to readout
        vecs[11] = mk(1, 1, 1, 0, 0, 2'd0, 0, 0, 0);
        vecs[12] = mk(1, 0, 1, 0, 1, 2'd2, 0, 1, 1);
        vecs[13] = mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 0, 0, 2'd1, 1, 0, 0); // writer absent at grant
        vecs[15] = mk(1, 1, 1, 0, 0, 2'd0, 0, 0, 0); // writer arrives late
        vecs[16] = mk(1, 0, 1, 0, 0, 2'd1, 1, 0, 0); // so readout wins tie
        vecs[17] = mk(1, 1, 1, 0, 0, 2'd0, 0, 0, 0);
        vecs[18] = mk(0, 0, 1, 0, 1, 2'd2, 0, 1, 1);
        vecs[19] = mk(0, 0, 1, 0, 1, 2'd2, 0, 0, 1);
        vecs[20] = mk(0, 0, 1, 0, 0, 2'd2, 0, 0, 0); // strobe low -> no write
        vecs[21] = mk(0, 0, 1, 0, 1, 2'd2, 0, 0, 1);

        // Reset state, with a writer strobe present.
        wr_ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_owner", owner, 2'd0);
        chk("rst_rd_gnt", rd_gnt, 1'b0);
        chk("rst_wr_gnt", wr_gnt, 1'b0);
        chk("rst_fb_wr_ena", fb_wr_ena, 1'b0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            rd_req = vecs[i].rr; rd_rel = vecs[i].rl;
            wr_req = vecs[i].wq; wr_rel = vecs[i].wl; wr_ena = vecs[i].we;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_owner", i), owner, e.own);
            chk($sformatf("v%0d_rd_gnt", i), rd_gnt, e.rg);
            chk($sformatf("v%0d_wr_gnt", i), wr_gnt, e.wg);
            chk($sformatf("v%0d_fb_wr_ena", i), fb_wr_ena, e.fe);
            chk($sformatf("v%0d_fb_addr", i), fb_addr, e.fa);
            chk($sformatf("v%0d_fb_wr_data", i), fb_wr_data, e.wd);
            chk($sformatf("v%0d_fb_wr_mask", i), fb_wr_mask, e.wm);
        end

        // Reset mid writer ownership, strobe high, request still held.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_owner", owner, 2'd0);
        chk("midrst_fb_wr_ena", fb_wr_ena, 1'b0);
        chk("midrst_wr_gnt", wr_gnt, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_hold_owner", owner, 2'd0);
        chk("midrst_hold_wr_gnt", wr_gnt, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_wr_gnt", wr_gnt, 1'b1);
        chk("postrst_owner", owner, 2'd2);
        chk("postrst_fb_wr_ena", fb_wr_ena, 1'b1);
        @(posedge clk);
        #1;
        chk("postrst_gnt_pulse", wr_gnt, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
